pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 tb/tb_pc_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with increment, absolute jump, relative
// branch and an optional return-address stack for call/ret.
// All state changes on the falling edge of clock; resetN is asynchronous.
// Optional feature macro: PC_SEQUENCER_STACK_EN (enables the call/ret stack).
module pc_sequencer #(
  parameter int WIDTH       = 16,
  parameter int RESET_ADDR  = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             stall,
  input  logic             incr_pc,
  input  logic             load,
  input  logic             rel,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] out,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_ADDR);

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] pc_rel;

  // Both adders wrap naturally at 2^WIDTH.
  assign pc_plus1 = pc_reg + WIDTH'(1);
  assign pc_rel   = pc_reg + offset;
  assign out      = pc_reg;

`ifdef PC_SEQUENCER_STACK_EN

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] FULL_CNT = DW'(STACK_DEPTH);

  logic [DW-1:0]    depth_reg;
  logic [DW-1:0]    depth_next;
  logic             err_reg;
  logic             err_next;
  logic             push;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top_val;
  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

  // Write slot is the current depth; top entry sits one below it.
  assign wr_idx  = depth_reg[AW-1:0];
  assign top_idx = AW'(depth_reg - DW'(1));
  // Unregistered read so ret lands the return address on the same edge.
  assign top_val = stack_mem[top_idx];

  assign stack_full  = (depth_reg == FULL_CNT);
  assign stack_empty = (depth_reg == '0);
  assign stack_err   = err_reg;

  // Priority decode: stall > ret > call > load > rel > incr_pc, else hold.
  always_comb begin
    pc_next    = pc_reg;
    depth_next = depth_reg;
    err_next   = err_reg;
    push       = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (stack_empty) begin
          err_next = 1'b1;
        end else begin
          pc_next    = top_val;
          depth_next = depth_reg - DW'(1);
        end
      end else if (call) begin
        if (stack_full) begin
          err_next = 1'b1;
        end else begin
          push       = 1'b1;
          pc_next    = in;
          depth_next = depth_reg + DW'(1);
        end
      end else if (load) begin
        pc_next = in;
      end else if (rel) begin
        pc_next = pc_rel;
      end else if (incr_pc) begin
        pc_next = pc_plus1;
      end
    end
  end

  // PC, depth and sticky error register; reset abandons any pending op.
  always_ff @(negedge clock or negedge resetN) begin
    if (!resetN) begin
      pc_reg    <= RST_PC;
      depth_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      depth_reg <= depth_next;
      err_reg   <= err_next;
    end
  end

  // Stack storage: contents are never cleared, only depth gates visibility.
  always_ff @(negedge clock) begin
    if (push) begin
      stack_mem[wr_idx] <= pc_plus1;
    end
  end

`else

  logic unused_ret;

  // Without a stack, ret carries no meaning.
  assign unused_ret  = ret;
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign stack_err   = 1'b0;

  // Priority decode without a stack: call degenerates to an absolute jump.
  always_comb begin
    pc_next = pc_reg;
    if (!stall) begin
      if (call || load) begin
        pc_next = in;
      end else if (rel) begin
        pc_next = pc_rel;
      end else if (incr_pc) begin
        pc_next = pc_plus1;
      end
    end
  end

  // PC register.
  always_ff @(negedge clock or negedge resetN) begin
    if (!resetN) begin
      pc_reg <= RST_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized traffic
// checked against a behavioural model (integer PC, queue as stack).
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        resetN;
  logic        stall, incr_pc, load, rel, call, ret;
  logic [15:0] in, offset;
  logic [15:0] out;
  logic        stack_full, stack_empty, stack_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_err;

  pc_sequencer #(.WIDTH(16), .RESET_ADDR(4), .STACK_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .stall      (stall),
    .incr_pc    (incr_pc),
    .load       (load),
    .rel        (rel),
    .call       (call),
    .ret        (ret),
    .in         (in),
    .offset     (offset),
    .out        (out),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err)
  );

  always #5 clock = ~clock;

  // Drive one set of requests, advance the model, wait past the falling edge.
  task automatic drive_edge(input bit s, input bit r, input bit c, input bit l,
                            input bit rl, input bit inc,
                            input logic [15:0] tgt, input logic [15:0] off);
    stall = s; ret = r; call = c; load = l; rel = rl; incr_pc = inc;
    in = tgt; offset = off;
    if (!s) begin
      if (r && STK) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else m_pc = m_stk.pop_back();
      end else if (c) begin
        if (STK && m_stk.size() == DEPTH) m_err = 1'b1;
        else begin
          if (STK) m_stk.push_back((m_pc + 1) % 65536);
          m_pc = int'(tgt);
        end
      end else if (l) m_pc = int'(tgt);
      else if (rl) m_pc = (m_pc + int'(off)) % 65536;
      else if (inc) m_pc = (m_pc + 1) % 65536;
    end
    @(negedge clock);
    #1;
  endtask

  task automatic load_pc(input logic [15:0] v);
    drive_edge(0, 0, 0, 1, 0, 0, v, 16'h0);
  endtask

  // Short reset pulse between two falling edges.
  task automatic do_reset();
    stall = 0; ret = 0; call = 0; load = 0; rel = 0; incr_pc = 0;
    #2 resetN = 1'b0;
    #1 resetN = 1'b1;
    m_pc = 4; m_stk.delete(); m_err = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    stall = 0; ret = 0; call = 0; load = 0; rel = 0; incr_pc = 1;
    in = 16'h0; offset = 16'h0;
    #22;
    checks++; if (out !== 16'h0004) begin failures++; $display("FAIL reset_out got=%h exp=0004", out); end
    checks++; if (stack_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", stack_empty); end
    checks++; if (stack_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", stack_full); end
    checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", stack_err); end
    resetN = 1'b1;
    m_pc = 4; m_stk.delete(); m_err = 1'b0;
    $display("reset: out=%h empty=%b full=%b err=%b", out, stack_empty, stack_full, stack_err);
  endtask

  task automatic test_incr();
    checks++; if (out !== 16'h0004) begin failures++; $display("FAIL incr_start got=%h exp=0004", out); end
    for (int i = 1; i <= 3; i++) begin
      drive_edge(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
      checks++;
      if (out !== 16'(4 + i)) begin failures++; $display("FAIL incr_%0d got=%h exp=%h", i, out, 16'(4 + i)); end
      $display("incr: out=%h", out);
    end
  endtask

  task automatic test_wrap();
    load_pc(16'hFFFF);
    drive_edge(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    checks++; if (out !== 16'h0000) begin failures++; $display("FAIL wrap_incr got=%h exp=0000", out); end
    $display("wrap incr: out=%h", out);
    load_pc(16'h0010);
    drive_edge(0, 0, 0, 0, 1, 0, 16'h0, 16'hFFF0);
    checks++; if (out !== 16'h0000) begin failures++; $display("FAIL wrap_rel_neg got=%h exp=0000", out); end
    $display("wrap rel: out=%h", out);
    load_pc(16'h0001);
    drive_edge(0, 0, 0, 0, 1, 0, 16'h0, 16'hFFFE);
    checks++; if (out !== 16'hFFFF) begin failures++; $display("FAIL wrap_rel_m1 got=%h exp=ffff", out); end
    $display("wrap rel2: out=%h", out);
  endtask

  task automatic test_priority();
    load_pc(16'h0030);
    drive_edge(1, 1, 0, 0, 0, 1, 16'h0, 16'h0);
    checks++; if (out !== 16'h0030) begin failures++; $display("FAIL prio_stall got=%h exp=0030", out); end
    checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL prio_stall_err got=%b exp=0", stack_err); end
    drive_edge(0, 0, 0, 1, 0, 1, 16'h0077, 16'h0);
    checks++; if (out !== 16'h0077) begin failures++; $display("FAIL prio_load_incr got=%h exp=0077", out); end
    drive_edge(0, 0, 0, 0, 1, 1, 16'h0, 16'h0003);
    checks++; if (out !== 16'h007A) begin failures++; $display("FAIL prio_rel_incr got=%h exp=007a", out); end
    drive_edge(0, 0, 0, 1, 1, 1, 16'h0123, 16'h0005);
    checks++; if (out !== 16'h0123) begin failures++; $display("FAIL prio_load_rel got=%h exp=0123", out); end
    drive_edge(0, 0, 0, 0, 0, 0, 16'h0999, 16'h0005);
    checks++; if (out !== 16'h0123) begin failures++; $display("FAIL prio_hold got=%h exp=0123", out); end
    $display("priority: out=%h", out);
  endtask

`ifdef PC_SEQUENCER_STACK_EN
  task automatic test_underflow();
    load_pc(16'h0042);
    drive_edge(0, 1, 0, 0, 0, 0, 16'h0, 16'h0);
    checks++; if (out !== 16'h0042) begin failures++; $display("FAIL underflow_out got=%h exp=0042", out); end
    checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL underflow_err got=%b exp=1", stack_err); end
    drive_edge(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", stack_err); end
    $display("underflow: out=%h err=%b", out, stack_err);
  endtask

  task automatic test_call_ret();
    load_pc(16'h0020);
    drive_edge(0, 0, 1, 0, 0, 0, 16'h0100, 16'h0);
    checks++; if (out !== 16'h0100) begin failures++; $display("FAIL call_out got=%h exp=0100", out); end
    checks++; if (stack_empty !== 1'b0) begin failures++; $display("FAIL call_empty got=%b exp=0", stack_empty); end
    drive_edge(0, 1, 1, 1, 0, 1, 16'h0555, 16'h0);
    checks++; if (out !== 16'h0021) begin failures++; $display("FAIL ret_out got=%h exp=0021", out); end
    checks++; if (stack_empty !== 1'b1) begin failures++; $display("FAIL ret_empty got=%b exp=1", stack_empty); end
    $display("call/ret: out=%h empty=%b", out, stack_empty);
  endtask

  task automatic test_overflow();
    logic [15:0] exp_ret [4];
    load_pc(16'h0010);
    for (int i = 0; i < 4; i++) begin
      drive_edge(0, 0, 1, 0, 0, 0, 16'(32 + 16 * i), 16'h0);
      checks++;
      if (out !== 16'(32 + 16 * i)) begin failures++; $display("FAIL nest_call_%0d got=%h exp=%h", i, out, 16'(32 + 16 * i)); end
    end
    checks++; if (stack_full !== 1'b1) begin failures++; $display("FAIL nest_full got=%b exp=1", stack_full); end
    checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL nest_err_pre got=%b exp=0", stack_err); end
    drive_edge(0, 0, 1, 0, 0, 0, 16'h0060, 16'h0);
    checks++; if (out !== 16'h0050) begin failures++; $display("FAIL overflow_out got=%h exp=0050", out); end
    checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL overflow_err got=%b exp=1", stack_err); end
    $display("overflow: out=%h full=%b err=%b", out, stack_full, stack_err);
    exp_ret[0] = 16'h0041; exp_ret[1] = 16'h0031; exp_ret[2] = 16'h0021; exp_ret[3] = 16'h0011;
    for (int i = 0; i < 4; i++) begin
      drive_edge(0, 1, 0, 0, 0, 0, 16'h0, 16'h0);
      checks++;
      if (out !== exp_ret[i]) begin failures++; $display("FAIL nest_ret_%0d got=%h exp=%h", i, out, exp_ret[i]); end
      $display("ret: out=%h", out);
    end
    checks++; if (stack_empty !== 1'b1) begin failures++; $display("FAIL nest_empty got=%b exp=1", stack_empty); end
  endtask
`else
  task automatic test_no_stack();
    load_pc(16'h0020);
    drive_edge(0, 0, 1, 0, 0, 0, 16'h0100, 16'h0);
    checks++; if (out !== 16'h0100) begin failures++; $display("FAIL nostk_call got=%h exp=0100", out); end
    drive_edge(0, 1, 0, 0, 0, 0, 16'h0, 16'h0);
    checks++; if (out !== 16'h0100) begin failures++; $display("FAIL nostk_ret_hold got=%h exp=0100", out); end
    drive_edge(0, 1, 0, 0, 0, 1, 16'h0, 16'h0);
    checks++; if (out !== 16'h0101) begin failures++; $display("FAIL nostk_ret_incr got=%h exp=0101", out); end
    drive_edge(0, 1, 0, 0, 1, 1, 16'h0, 16'h0002);
    checks++; if (out !== 16'h0103) begin failures++; $display("FAIL nostk_ret_rel got=%h exp=0103", out); end
    for (int i = 0; i < 6; i++) drive_edge(0, 0, 1, 0, 0, 0, 16'(16'h0200 + i), 16'h0);
    checks++; if (out !== 16'h0205) begin failures++; $display("FAIL nostk_many_calls got=%h exp=0205", out); end
    checks++;
    if (stack_full !== 1'b0 || stack_empty !== 1'b1 || stack_err !== 1'b0) begin
      failures++;
      $display("FAIL nostk_flags got=%b%b%b exp=010", stack_full, stack_empty, stack_err);
    end
    $display("no-stack: out=%h flags=%b%b%b", out, stack_full, stack_empty, stack_err);
  endtask
`endif

  task automatic test_async_reset();
    load_pc(16'h0050);
    drive_edge(0, 0, 1, 0, 0, 0, 16'h0060, 16'h0);
    drive_edge(0, 0, 1, 0, 0, 0, 16'h0070, 16'h0);
    // Reset strikes while a further call is being requested.
    in = 16'h0080;
    #2 resetN = 1'b0;
    #1;
    checks++; if (out !== 16'h0004) begin failures++; $display("FAIL areset_out got=%h exp=0004", out); end
    checks++; if (stack_empty !== 1'b1) begin failures++; $display("FAIL areset_empty got=%b exp=1", stack_empty); end
    checks++; if (stack_full !== 1'b0) begin failures++; $display("FAIL areset_full got=%b exp=0", stack_full); end
    checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL areset_err got=%b exp=0", stack_err); end
    #1 resetN = 1'b1;
    m_pc = 4; m_stk.delete(); m_err = 1'b0;
    #1;
    checks++; if (out !== 16'h0004) begin failures++; $display("FAIL areset_hold got=%h exp=0004", out); end
    drive_edge(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    checks++; if (out !== 16'h0005) begin failures++; $display("FAIL areset_first got=%h exp=0005", out); end
    $display("async reset: out=%h empty=%b err=%b", out, stack_empty, stack_err);
  endtask

  task automatic test_random();
    bit exp_full, exp_empty;
    for (int n = 0; n < 300; n++) begin
      if (n % 75 == 74) do_reset();
      drive_edge($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
                 16'($urandom), 16'($urandom));
      exp_full  = STK ? (m_stk.size() == DEPTH) : 1'b0;
      exp_empty = STK ? (m_stk.size() == 0) : 1'b1;
      checks++; if (out !== 16'(m_pc)) begin failures++; $display("FAIL rnd_out n=%0d got=%h exp=%h", n, out, 16'(m_pc)); end
      checks++; if (stack_full !== exp_full) begin failures++; $display("FAIL rnd_full n=%0d got=%b exp=%b", n, stack_full, exp_full); end
      checks++; if (stack_empty !== exp_empty) begin failures++; $display("FAIL rnd_empty n=%0d got=%b exp=%b", n, stack_empty, exp_empty); end
      checks++; if (stack_err !== m_err) begin failures++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, stack_err, m_err); end
      $display("rnd %0d: ctl=%b%b%b%b%b%b in=%h off=%h out=%h depth=%0d err=%b",
               n, stall, ret, call, load, rel, incr_pc, in, offset, out, m_stk.size(), stack_err);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_priority();
`ifdef PC_SEQUENCER_STACK_EN
    do_reset();
    test_underflow();
    do_reset();
    test_call_ret();
    test_overflow();
    do_reset();
`else
    test_no_stack();
`endif
    test_async_reset();
    do_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
